// File: rtl/digital_clock_pkg.sv
// ============================================================================
// Module  : digital_clock_pkg
// Brief   : Shared widths, limits, state encodings and wrap helpers for the clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

package digital_clock_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;

   localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
   localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      SET_HOUR  = 3'd1,
      SET_MIN   = 3'd2,
      SET_AHOUR = 3'd3,
      SET_AMIN  = 3'd4
   } set_mode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } ring_state_t;

   function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
      return (h >= MAX_HOUR) ? '0 : h + 1'b1;
   endfunction

   function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
      return (m >= MAX_MIN) ? '0 : m + 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/clock_ctrl_if.sv
// ============================================================================
// Module  : clock_ctrl_if
// Brief   : Button, live-time and control/alarm signals between UI, datapath and controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface clock_ctrl_if;
   import digital_clock_pkg::*;

   logic              btn_mode;
   logic              btn_inc;
   logic              btn_snooze;
   logic [HOUR_W-1:0] cur_hour;
   logic [MIN_W-1:0]  cur_min;
   logic [MIN_W-1:0]  cur_sec;
   logic              tick_en;
   logic              load_en;
   logic [HOUR_W-1:0] load_hour;
   logic [MIN_W-1:0]  load_min;
   logic [MIN_W-1:0]  load_sec;
   logic [HOUR_W-1:0] alarm_hour;
   logic [MIN_W-1:0]  alarm_min;
   logic              alarm_armed;
   logic              ring;
   logic [2:0]        mode;

   modport master (
      output btn_mode, btn_inc, btn_snooze, cur_hour, cur_min, cur_sec,
      input  tick_en, load_en, load_hour, load_min, load_sec,
             alarm_hour, alarm_min, alarm_armed, ring, mode
   );

   modport slave (
      input  btn_mode, btn_inc, btn_snooze, cur_hour, cur_min, cur_sec,
      output tick_en, load_en, load_hour, load_min, load_sec,
             alarm_hour, alarm_min, alarm_armed, ring, mode
   );

endinterface

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module  : tick_prescaler
// Brief   : Divides clk down to a one-cycle tick_en every CLK_HZ cycles; hold freezes it at 0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic hold,
   output logic tick_en
);

   localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q + 1'b1;
      if (hold || count_q == LAST) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_en = !hold && (count_q == LAST);

endmodule

`default_nettype wire

// File: rtl/clock_ctrl.sv
// ============================================================================
// Module  : clock_ctrl
// Brief   : Time-set sequencer, parallel-load strobe, alarm storage and ring/snooze FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module clock_ctrl
   import digital_clock_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int SNOOZE_S       = 300,
   parameter int RING_TIMEOUT_S = 60
) (
   input  logic        clk,
   input  logic        reset_n,
   clock_ctrl_if.slave bus
);

   localparam int SW = $clog2(SNOOZE_S + 1);
   localparam int TW = $clog2(RING_TIMEOUT_S + 1);

   set_mode_t         mode_q;
   ring_state_t       ring_q;
   logic [HOUR_W-1:0] edit_hour_q;
   logic [MIN_W-1:0]  edit_min_q;
   logic [HOUR_W-1:0] alarm_hour_q;
   logic [MIN_W-1:0]  alarm_min_q;
   logic              armed_q;
   logic              load_en_q;
   logic              match_q;
   logic [SW-1:0]     snooze_q;
   logic [TW-1:0]     timeout_q;

   logic tick;
   logic hold;
   logic match;
   logic dismiss;
   logic mode_evt;
   logic inc_evt;
   logic disarm;

   assign hold     = (mode_q == SET_HOUR) || (mode_q == SET_MIN);
   assign match    = armed_q && (bus.cur_hour == alarm_hour_q) &&
                     (bus.cur_min == alarm_min_q) && (bus.cur_sec == '0);
   // A mode press that silences the alarm must not also step the set sequence.
   assign dismiss  = bus.btn_mode && (ring_q == RINGING);
   assign mode_evt = bus.btn_mode && !dismiss;
   assign inc_evt  = bus.btn_inc && !bus.btn_mode;
   assign disarm   = inc_evt && (mode_q == RUN) && armed_q;

   tick_prescaler #(
      .CLK_HZ (CLK_HZ)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .hold    (hold),
      .tick_en (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_q       <= RUN;
         edit_hour_q  <= '0;
         edit_min_q   <= '0;
         alarm_hour_q <= '0;
         alarm_min_q  <= '0;
         armed_q      <= 1'b0;
         load_en_q    <= 1'b0;
      end else begin
         load_en_q <= 1'b0;
         if (mode_evt) begin
            case (mode_q)
               RUN: begin
                  edit_hour_q <= bus.cur_hour;
                  edit_min_q  <= bus.cur_min;
                  mode_q      <= SET_HOUR;
               end
               SET_HOUR:  mode_q <= SET_MIN;
               SET_MIN: begin
                  mode_q    <= SET_AHOUR;
                  load_en_q <= 1'b1;
               end
               SET_AHOUR: mode_q <= SET_AMIN;
               default:   mode_q <= RUN;
            endcase
         end else if (inc_evt) begin
            case (mode_q)
               RUN:       armed_q      <= !armed_q;
               SET_HOUR:  edit_hour_q  <= hour_inc(edit_hour_q);
               SET_MIN:   edit_min_q   <= min_inc(edit_min_q);
               SET_AHOUR: alarm_hour_q <= hour_inc(alarm_hour_q);
               default:   alarm_min_q  <= min_inc(alarm_min_q);
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ring_q    <= IDLE;
         match_q   <= 1'b0;
         snooze_q  <= '0;
         timeout_q <= '0;
      end else begin
         match_q <= match;
         case (ring_q)
            IDLE: begin
               if (match && !match_q) begin
                  ring_q    <= RINGING;
                  timeout_q <= TW'(RING_TIMEOUT_S);
               end
            end
            RINGING: begin
               if (dismiss || disarm) begin
                  ring_q <= IDLE;
               end else if (bus.btn_snooze) begin
                  ring_q   <= SNOOZE;
                  snooze_q <= SW'(SNOOZE_S);
               end else if (tick) begin
                  if (timeout_q <= TW'(1)) begin
                     ring_q <= IDLE;
                  end else begin
                     timeout_q <= timeout_q - 1'b1;
                  end
               end
            end
            SNOOZE: begin
               if (disarm) begin
                  ring_q <= IDLE;
               end else if (tick) begin
                  if (snooze_q <= SW'(1)) begin
                     ring_q    <= RINGING;
                     timeout_q <= TW'(RING_TIMEOUT_S);
                  end else begin
                     snooze_q <= snooze_q - 1'b1;
                  end
               end
            end
            default: ring_q <= IDLE;
         endcase
      end
   end

   assign bus.tick_en     = tick;
   assign bus.load_en     = load_en_q;
   assign bus.load_hour   = edit_hour_q;
   assign bus.load_min    = edit_min_q;
   assign bus.load_sec    = '0;
   assign bus.alarm_hour  = alarm_hour_q;
   assign bus.alarm_min   = alarm_min_q;
   assign bus.alarm_armed = armed_q;
   assign bus.ring        = (ring_q == RINGING);
   assign bus.mode        = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_ctrl.sv
// ============================================================================
// Module  : tb_clock_ctrl
// Brief   : Directed scenarios plus random buttons/time against a cycle model of the controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_clock_ctrl;

   localparam int CLK_HZ         = 4;
   localparam int SNOOZE_S       = 6;
   localparam int RING_TIMEOUT_S = 5;
   localparam int R_IDLE = 0, R_RING = 1, R_SNZ = 2;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   clock_ctrl_if bus ();

   clock_ctrl #(
      .CLK_HZ         (CLK_HZ),
      .SNOOZE_S       (SNOOZE_S),
      .RING_TIMEOUT_S (RING_TIMEOUT_S)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference state: mode 0..4, times as plain integers, ring 0/1/2 with remaining-tick counts.
   int m_mode, m_eh, m_em, m_ah, m_am, m_armed, m_load;
   int m_ring, m_snz_left, m_to_left, m_pres, m_match_prev;
   int cur_h, cur_m, cur_s;
   int last_tick;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0; m_armed = 0; m_load = 0;
      m_ring = R_IDLE; m_snz_left = 0; m_to_left = 0; m_pres = 0; m_match_prev = 0;
   endtask

   task automatic step(input bit bm, input bit bi, input bit bs);
      bit frozen, tick, match, dismiss, mode_evt, inc_evt, disarm;
      bus.btn_mode   = bm;
      bus.btn_inc    = bi;
      bus.btn_snooze = bs;
      bus.cur_hour   = 5'(cur_h);
      bus.cur_min    = 6'(cur_m);
      bus.cur_sec    = 6'(cur_s);
      #1;
      frozen = (m_mode == 1) || (m_mode == 2);
      tick   = !frozen && (m_pres == CLK_HZ - 1);
      chk("tick_en", int'(bus.tick_en), int'(tick));
      last_tick = int'(tick);

      match    = (m_armed != 0) && cur_h == m_ah && cur_m == m_am && cur_s == 0;
      dismiss  = bm && m_ring == R_RING;
      mode_evt = bm && !dismiss;
      inc_evt  = bi && !bm;
      disarm   = inc_evt && m_mode == 0 && m_armed != 0;

      case (m_ring)
         R_IDLE: if (match && m_match_prev == 0) begin m_ring = R_RING; m_to_left = RING_TIMEOUT_S; end
         R_RING: begin
            if (dismiss || disarm) m_ring = R_IDLE;
            else if (bs) begin m_ring = R_SNZ; m_snz_left = SNOOZE_S; end
            else if (tick) begin
               m_to_left--;
               if (m_to_left == 0) m_ring = R_IDLE;
            end
         end
         default: begin
            if (disarm) m_ring = R_IDLE;
            else if (tick) begin
               m_snz_left--;
               if (m_snz_left == 0) begin m_ring = R_RING; m_to_left = RING_TIMEOUT_S; end
            end
         end
      endcase
      m_match_prev = int'(match);
      m_pres = frozen ? 0 : (m_pres + 1) % CLK_HZ;

      m_load = 0;
      if (mode_evt) begin
         if (m_mode == 0) begin m_eh = cur_h; m_em = cur_m; end
         if (m_mode == 2) m_load = 1;
         m_mode = (m_mode + 1) % 5;
      end else if (inc_evt) begin
         case (m_mode)
            0: m_armed = 1 - m_armed;
            1: m_eh = (m_eh + 1) % 24;
            2: m_em = (m_em + 1) % 60;
            3: m_ah = (m_ah + 1) % 24;
            default: m_am = (m_am + 1) % 60;
         endcase
      end

      @(posedge clk);
      #1;
      bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_snooze = 1'b0;
      chk("mode",        int'(bus.mode),        m_mode);
      chk("load_en",     int'(bus.load_en),     m_load);
      chk("load_hour",   int'(bus.load_hour),   m_eh);
      chk("load_min",    int'(bus.load_min),    m_em);
      chk("load_sec",    int'(bus.load_sec),    0);
      chk("alarm_hour",  int'(bus.alarm_hour),  m_ah);
      chk("alarm_min",   int'(bus.alarm_min),   m_am);
      chk("alarm_armed", int'(bus.alarm_armed), m_armed);
      chk("ring",        int'(bus.ring),        int'(m_ring == R_RING));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   // Reset lands between clock edges; outputs must clear before any edge arrives.
   task automatic async_reset(input string tag);
      #2;
      reset_n = 1'b0;
      #1;
      chk({tag, "_ring"},  int'(bus.ring),        0);
      chk({tag, "_mode"},  int'(bus.mode),        0);
      chk({tag, "_ahour"}, int'(bus.alarm_hour),  0);
      chk({tag, "_amin"},  int'(bus.alarm_min),   0);
      chk({tag, "_armed"}, int'(bus.alarm_armed), 0);
      chk({tag, "_load"},  int'(bus.load_en),     0);
      bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_snooze = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_load_held"}, int'(bus.load_en), 0);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic rearm_and_ring();
      cur_h = 7; cur_m = 30; cur_s = 1;
      step(1'b0, 1'b0, 1'b0);
      cur_s = 0;
      step(1'b0, 1'b0, 1'b0);
   endtask

   int n;
   bit got;

   initial begin
      bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; bus.btn_snooze = 1'b0;
      bus.cur_hour = '0; bus.cur_min = '0; bus.cur_sec = '0;
      cur_h = 0; cur_m = 0; cur_s = 0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_mode",  int'(bus.mode),        0);
      chk("rst_ring",  int'(bus.ring),        0);
      chk("rst_tick",  int'(bus.tick_en),     0);
      chk("rst_armed", int'(bus.alarm_armed), 0);
      reset_n = 1'b1;

      // Free running: ticks on the 4th, 8th, 12th cycle after release.
      idle(13);

      // Time set 22:10 -> 01:00 with wraps, then load.
      cur_h = 22; cur_m = 10; cur_s = 5;
      step(1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      repeat (50) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("set_load_en", int'(bus.load_en),   1);
      chk("set_load_h",  int'(bus.load_hour), 1);
      chk("set_load_m",  int'(bus.load_min),  0);
      chk("set_mode3",   int'(bus.mode),      3);

      // Alarm 07:30 then back to RUN and arm.
      repeat (7) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      repeat (30) step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("armed", int'(bus.alarm_armed), 1);
      cur_h = 7; cur_m = 30; cur_s = 0;
      step(1'b0, 1'b0, 1'b0);
      chk("ring_start", int'(bus.ring), 1);
      n = 0; got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (last_tick != 0) n++;
         if (!bus.ring) got = 1'b1;
      end
      chk("timeout_ticks", n, RING_TIMEOUT_S);
      idle(30);
      chk("no_retrigger", int'(bus.ring), 0);

      // Snooze then disarm while ringing.
      rearm_and_ring();
      step(1'b0, 1'b0, 1'b1);
      chk("snooze_quiet", int'(bus.ring), 0);
      cur_s = 9;
      n = 0; got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         step(1'b0, 1'b0, 1'b0);
         if (last_tick != 0) n++;
         if (bus.ring) got = 1'b1;
      end
      chk("snooze_ticks", n, SNOOZE_S);
      step(1'b0, 1'b1, 1'b0);
      chk("disarm_armed", int'(bus.alarm_armed), 0);
      chk("disarm_ring",  int'(bus.ring),        0);

      // Mode + snooze together: dismiss wins, set FSM stays in RUN.
      step(1'b0, 1'b1, 1'b0);
      rearm_and_ring();
      step(1'b1, 1'b0, 1'b1);
      chk("dismiss_ring", int'(bus.ring), 0);
      chk("dismiss_mode", int'(bus.mode), 0);
      idle(3 * CLK_HZ);

      // Async reset while ringing.
      rearm_and_ring();
      async_reset("ar_ring");
      idle(6);

      // Async reset with a commit press pending in SET_MIN.
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("edit_mode2", int'(bus.mode), 2);
      bus.btn_mode = 1'b1;
      async_reset("ar_edit");
      idle(4);

      // Randomised buttons and time, biased towards the alarm minute.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            cur_h = m_ah; cur_m = m_am; cur_s = $urandom_range(0, 1);
         end else begin
            cur_h = $urandom_range(0, 23); cur_m = $urandom_range(0, 59); cur_s = $urandom_range(0, 59);
         end
         step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Control block for the hh:mm:ss digital clock datapath.
- Generates the 1 Hz tick enable for the datapath and sequences time-setting through a mode-button FSM.
- Issues a one-cycle parallel load into the datapath when a new time is committed.
- Owns the alarm setting, arm state and a ringing/snooze/timeout FSM.
- Sits between the debounced user buttons and the clock counter block.

Parameters:
- CLK_HZ, 50_000_000, input clock cycles per tick_en pulse (set to 4 in simulation).
- SNOOZE_S, 300, snooze length in ticks.
- RING_TIMEOUT_S, 60, ticks of unattended ringing before auto-stop.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- btn_mode  in  1  synchronised single-cycle pulse.
- btn_inc  in  1  synchronised single-cycle pulse.
- btn_snooze  in  1  synchronised single-cycle pulse.
- cur_hour  in  5  live hour from clock datapath.
- cur_min  in  6  live minute from clock datapath.
- cur_sec  in  6  live second from clock datapath.
- tick_en  out  1  one-cycle 1 Hz enable to datapath.
- load_en  out  1  one-cycle load strobe to datapath.
- load_hour  out  5  hour value to load.
- load_min  out  6  minute value to load.
- load_sec  out  6  second value to load; constant 0.
- alarm_hour  out  5  stored alarm hour.
- alarm_min  out  6  stored alarm minute.
- alarm_armed  out  1  alarm enabled.
- ring  out  1  alarm sounding.
- mode  out  3  current set-FSM state.

Behaviour:
- Reset (reset_n=0, async): all outputs and internal registers 0; mode=RUN; ring FSM=IDLE; prescaler=0.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps.
  - tick_en=1 for exactly the cycle in which the count equals CLK_HZ-1.
  - First pulse appears CLK_HZ cycles after reset release.
  - In SET_HOUR and SET_MIN, the prescaler is held at 0 and tick_en=0; the clock is frozen.
- Set FSM (mode encoding):
  - States: RUN=0, SET_HOUR=1, SET_MIN=2, SET_AHOUR=3, SET_AMIN=4.
  - btn_mode advances RUN→SET_HOUR→SET_MIN→SET_AHOUR→SET_AMIN→RUN.
  - RUN→SET_HOUR: edit_hour<=cur_hour, edit_min<=cur_min.
  - btn_inc in SET_HOUR: edit_hour+1, wrapping 23→0.
  - btn_inc in SET_MIN: edit_min+1, wrapping 59→0.
  - SET_MIN→SET_AHOUR: load_en=1 for one cycle (the cycle after the btn_mode pulse).
  - load_hour/load_min continuously show edit_hour/edit_min; load_sec=0.
  - btn_inc in SET_AHOUR / SET_AMIN increments alarm_hour / alarm_min with the same wrap rules.
  - btn_inc in RUN toggles alarm_armed.
  - btn_mode and btn_inc in the same cycle: mode wins, inc dropped.
- Ring FSM (IDLE, RINGING, SNOOZE):
  - match = alarm_armed & cur_hour==alarm_hour & cur_min==alarm_min & cur_sec==0.
  - IDLE→RINGING on rising edge of match (registered match_d); a single match second fires once.
  - ring=1 only in RINGING.
  - RINGING: btn_snooze→SNOOZE, with snooze counter loaded to SNOOZE_S.
  - RINGING: btn_mode→IDLE; that press is consumed and the set FSM does not advance.
  - RINGING: after RING_TIMEOUT_S tick_en pulses without action→IDLE.
  - SNOOZE: counter decrements on tick_en; on reaching 0→RINGING, with the timeout counter reloaded.
  - btn_inc in RUN that clears alarm_armed while in RINGING or SNOOZE→IDLE.
  - btn_mode and btn_snooze together while RINGING: dismiss wins→IDLE.
  - Ring FSM counters only advance on tick_en; they freeze while the clock is frozen.
- Reset mid-operation: everything returns to reset values immediately.
  - Alarm settings are lost.
  - A pending load is discarded; no load_en pulse.

Decomposition:
- Package digital_clock_pkg:
  - MAX_HOUR=23, MAX_MIN=59.
  - HOUR_W=5, MIN_W=6.
  - Enums set_mode_t (RUN..SET_AMIN, 3 bits) and ring_state_t (IDLE, RINGING, SNOOZE).
- Sub-module tick_prescaler:
  - Parameter CLK_HZ.
  - Ports clk, reset_n, hold, tick_en.
  - Instantiated once.

Test Plan:
- CLK_HZ=4, release reset, idle → tick_en high at cycles 4, 8, 12 after release; all other outputs 0; mode=0.
- cur=22:10:xx; mode, inc×3, mode, inc×50, mode → edit_hour 22→1; edit_min 10→0; load_en one cycle with load 01:00:00; mode=3; no tick_en while mode∈{1,2}.
- Set alarm 07:30 (mode×3, inc×7, mode, inc×30, mode); inc in RUN arms; drive cur 07:30:00 → ring=1 next cycle; ring=0 after RING_TIMEOUT_S ticks; holding cur_sec at 0 does not retrigger.
- Ringing, btn_snooze → ring=0; ring=1 exactly on the SNOOZE_S-th tick_en; then inc in RUN → alarm_armed=0, ring=0.
- Ringing, btn_mode+btn_snooze same cycle → ring=0, ring FSM IDLE, mode stays RUN.
- Ringing, or mid-edit with mode=2, assert reset_n=0 asynchronously → ring, mode, alarm_* return to 0 with no clock edge; no load_en pulse.
